// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM with memory wait states.
// Define MC_INSTR_CNT_EN to add the 32-bit retired-instruction counter instr_cnt.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  OP,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCEn,
    output logic        IorD,
    output logic        MemRd,
    output logic        MemWr,
    output logic        IRWr,
    output logic        RegWr,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUop,
    output logic        ExtOp,
    output logic [1:0]  PCSrc,
    output logic        illegal,
    output logic        instr_done,
`ifdef MC_INSTR_CNT_EN
    output logic [31:0] instr_cnt,
`endif
    output logic [3:0]  state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_IEXEC  = 4'd10;
    localparam logic [3:0] S_IWB    = 4'd11;

    localparam logic [2:0] C_R     = 3'd0;
    localparam logic [2:0] C_LW    = 3'd1;
    localparam logic [2:0] C_SW    = 3'd2;
    localparam logic [2:0] C_ORI   = 3'd3;
    localparam logic [2:0] C_ADDIU = 3'd4;
    localparam logic [2:0] C_BEQ   = 3'd5;
    localparam logic [2:0] C_BNE   = 3'd6;
    localparam logic [2:0] C_J     = 3'd7;

    logic [3:0] state_q, state_d;
    logic [2:0] opc_q, opc_d;

    logic [2:0] dec_cls;
    logic [3:0] dec_nxt;
    logic       dec_ok;

    logic       pcen, iord, memrd, memwr, irwr;
    logic       regwr, regdst, memtoreg, srca, extop;
    logic       ill, done;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluop;

    always_comb begin
        dec_cls = C_R;
        dec_nxt = S_FETCH;
        dec_ok  = 1'b1;
        case (OP)
            6'b000000: begin dec_cls = C_R;     dec_nxt = S_EXEC;   end
            6'b100011: begin dec_cls = C_LW;    dec_nxt = S_MEMADR; end
            6'b101011: begin dec_cls = C_SW;    dec_nxt = S_MEMADR; end
            6'b001101: begin dec_cls = C_ORI;   dec_nxt = S_IEXEC;  end
            6'b001001: begin dec_cls = C_ADDIU; dec_nxt = S_IEXEC;  end
            6'b000100: begin dec_cls = C_BEQ;   dec_nxt = S_BRANCH; end
            6'b000101: begin dec_cls = C_BNE;   dec_nxt = S_BRANCH; end
            6'b000010: begin dec_cls = C_J;     dec_nxt = S_JUMP;   end
            default:   dec_ok = 1'b0;
        endcase
    end

    // Opcode is only trusted in DECODE; later states use the latched class.
    assign opc_d = (state_q == S_DECODE) ? dec_cls : opc_q;

    always_comb begin
        pcen     = 1'b0;
        iord     = 1'b0;
        memrd    = 1'b0;
        memwr    = 1'b0;
        irwr     = 1'b0;
        regwr    = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        srca     = 1'b0;
        srcb     = 2'b00;
        aluop    = 3'b000;
        extop    = 1'b0;
        pcsrc    = 2'b00;
        ill      = 1'b0;
        done     = 1'b0;
        state_d  = S_FETCH;
        case (state_q)
            S_FETCH: begin
                memrd   = 1'b1;
                srcb    = 2'b01;
                irwr    = mem_ready;
                pcen    = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                srcb  = 2'b11;
                extop = 1'b1;
                if (dec_ok) begin
                    state_d = dec_nxt;
                end else begin
                    ill     = 1'b1;
                    done    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                srca    = 1'b1;
                srcb    = 2'b10;
                extop   = 1'b1;
                state_d = (opc_q == C_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memrd   = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwr    = 1'b1;
                memtoreg = 1'b1;
                done     = 1'b1;
            end
            S_MEMWR: begin
                memwr   = 1'b1;
                iord    = 1'b1;
                done    = mem_ready;
                state_d = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                srca    = 1'b1;
                aluop   = 3'b001;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwr  = 1'b1;
                regdst = 1'b1;
                done   = 1'b1;
            end
            S_IEXEC: begin
                srca = 1'b1;
                srcb = 2'b10;
                if (opc_q == C_ORI) begin
                    aluop = 3'b010;
                end else begin
                    extop = 1'b1;
                end
                state_d = S_IWB;
            end
            S_IWB: begin
                regwr = 1'b1;
                done  = 1'b1;
            end
            S_BRANCH: begin
                srca  = 1'b1;
                aluop = 3'b100;
                pcsrc = 2'b01;
                pcen  = (opc_q == C_BNE) ? !Zero : Zero;
                done  = 1'b1;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            opc_q   <= C_R;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    // FETCH decodes to MemRd=1, so outputs are masked while reset is held.
    assign PCEn       = rst_n & pcen;
    assign IorD       = rst_n & iord;
    assign MemRd      = rst_n & memrd;
    assign MemWr      = rst_n & memwr;
    assign IRWr       = rst_n & irwr;
    assign RegWr      = rst_n & regwr;
    assign RegDst     = rst_n & regdst;
    assign MemtoReg   = rst_n & memtoreg;
    assign ALUSrcA    = rst_n & srca;
    assign ALUSrcB    = rst_n ? srcb : 2'b00;
    assign ALUop      = rst_n ? aluop : 3'b000;
    assign ExtOp      = rst_n & extop;
    assign PCSrc      = rst_n ? pcsrc : 2'b00;
    assign illegal    = rst_n & ill;
    assign instr_done = rst_n & done;
    assign state      = state_q;

`ifdef MC_INSTR_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = instr_done ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_cnt = cnt_q;
`endif

endmodule
